// File: rtl/led_fade_pkg.sv
// Shared constants, level type and saturating step helper for the LED fade driver.
package led_fade_pkg;

    localparam int TICK_DIV_DEFAULT = 97656;
    localparam int STEP_DEFAULT     = 8;
    localparam int LVL_BITS         = 8;

    typedef logic [LVL_BITS-1:0] lvl_t;

    // One brightness step toward full (up=1) or off (up=0), clamped to [0, max_lvl].
    function automatic logic [31:0] sat_step(input logic [31:0] lvl,
                                             input logic [31:0] step,
                                             input logic [31:0] max_lvl,
                                             input logic        up);
        logic [32:0] sum;
        sum = {1'b0, lvl} + {1'b0, step};
        if (up) begin
            sat_step = (sum > {1'b0, max_lvl}) ? max_lvl : sum[31:0];
        end else begin
            sat_step = (lvl < step) ? 32'd0 : (lvl - step);
        end
    endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One fade channel: brightness level register, saturating ramp, PWM compare
// and the registered, polarity-adjusted pin drive.
module led_fade_channel
    import led_fade_pkg::*;
#(
    parameter int PWM_BITS   = LVL_BITS,
    parameter int STEP       = STEP_DEFAULT,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                clk,
    input  logic                srst,
    input  logic                enable_i,
    input  logic                tick_i,
    input  logic                tgt_i,
    input  logic [PWM_BITS-1:0] pwm_cnt_i,
    output logic                led_o,
    output logic [PWM_BITS-1:0] lvl_o
);

    localparam logic [PWM_BITS-1:0] LVL_MAX = '1;
    localparam logic                LED_OFF = (ACTIVE_LOW != 0);

    logic [PWM_BITS-1:0] lvl_q;
    logic [PWM_BITS-1:0] lvl_d;
    logic                raw_on;
    logic                led_q;

    always_comb begin
        lvl_d = lvl_q;
        if (!enable_i) begin
            lvl_d = '0;
        end else if (tick_i) begin
            lvl_d = PWM_BITS'(sat_step(32'(lvl_q), 32'(STEP), 32'(LVL_MAX), tgt_i));
        end
    end

    // Endpoints bypass the compare so full level is a true 100% duty.
    always_comb begin
        if (lvl_q == '0) begin
            raw_on = 1'b0;
        end else if (lvl_q == LVL_MAX) begin
            raw_on = 1'b1;
        end else begin
            raw_on = (lvl_q > pwm_cnt_i);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            lvl_q <= '0;
            led_q <= LED_OFF;
        end else begin
            lvl_q <= lvl_d;
            led_q <= enable_i ? (raw_on ^ LED_OFF) : LED_OFF;
        end
    end

    assign led_o = led_q;
    assign lvl_o = lvl_q;

endmodule

// File: rtl/led_fade_driver.sv
// Soft-fade PWM output stage between the LED slave pattern and the board pins.
// Owns the target register, brightness tick divider, PWM counter and busy flag.
module led_fade_driver
    import led_fade_pkg::*;
#(
    parameter int CH_NUM     = 8,
    parameter int PWM_BITS   = LVL_BITS,
    parameter int TICK_DIV   = TICK_DIV_DEFAULT,
    parameter int STEP       = STEP_DEFAULT,
    parameter int ACTIVE_LOW = 0
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic [CH_NUM-1:0] led_in,
    input  logic              enable,
    output logic [CH_NUM-1:0] led_out,
    output logic              busy
);

    localparam int                  CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]    TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [PWM_BITS-1:0] LVL_MAX   = '1;

    logic [CH_NUM-1:0]   tgt_q;
    logic [CNT_W-1:0]    tick_cnt_q;
    logic [CNT_W-1:0]    tick_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic                busy_q;
    logic                busy_d;
    logic                tick;
    logic [CH_NUM-1:0]   off_target;
    logic [PWM_BITS-1:0] lvl [CH_NUM];

    assign tick = enable && (tick_cnt_q == TICK_LAST);

    always_comb begin
        tick_cnt_d = tick_cnt_q + CNT_W'(1);
        if (!enable || (tick_cnt_q == TICK_LAST)) begin
            tick_cnt_d = '0;
        end
    end

    generate
        for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
            led_fade_channel #(
                .PWM_BITS   (PWM_BITS),
                .STEP       (STEP),
                .ACTIVE_LOW (ACTIVE_LOW)
            ) u_ch (
                .clk       (HCLK),
                .srst      (HRESET),
                .enable_i  (enable),
                .tick_i    (tick),
                .tgt_i     (tgt_q[gi]),
                .pwm_cnt_i (pwm_cnt_q),
                .led_o     (led_out[gi]),
                .lvl_o     (lvl[gi])
            );

            assign off_target[gi] = (lvl[gi] != (tgt_q[gi] ? LVL_MAX : '0));
        end
    endgenerate

    assign busy_d = enable && (|off_target);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            tgt_q      <= '0;
            tick_cnt_q <= '0;
            pwm_cnt_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            tgt_q      <= led_in;
            tick_cnt_q <= tick_cnt_d;
            pwm_cnt_q  <= pwm_cnt_q + PWM_BITS'(1);
            busy_q     <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_led_fade_driver.sv
// Randomized and directed bench for led_fade_driver, checked every cycle
// against a behavioural fade/PWM model kept in the bench.
module tb_led_fade_driver;

    localparam int TD      = 4;
    localparam int TD_SLOW = 1000;
    localparam int STEPV   = 64;
    localparam int MAXL    = 255;

    logic       clk = 1'b0;
    logic       HRESET = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] led_in = 8'h00;
    logic [7:0] led_out, led_out_al, led_out_slow;
    logic       busy, busy_al, busy_slow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_fade_driver #(.CH_NUM(8), .PWM_BITS(8), .TICK_DIV(TD), .STEP(STEPV), .ACTIVE_LOW(0)) u_dut (
        .HCLK(clk), .HRESET(HRESET), .led_in(led_in), .enable(enable),
        .led_out(led_out), .busy(busy));

    led_fade_driver #(.CH_NUM(8), .PWM_BITS(8), .TICK_DIV(TD), .STEP(STEPV), .ACTIVE_LOW(1)) u_dut_al (
        .HCLK(clk), .HRESET(HRESET), .led_in(led_in), .enable(enable),
        .led_out(led_out_al), .busy(busy_al));

    led_fade_driver #(.CH_NUM(8), .PWM_BITS(8), .TICK_DIV(TD_SLOW), .STEP(STEPV), .ACTIVE_LOW(0)) u_slow (
        .HCLK(clk), .HRESET(HRESET), .led_in(led_in), .enable(enable),
        .led_out(led_out_slow), .busy(busy_slow));

    // ---------------- behavioural model ----------------
    int         m_cnt;
    int         m_pwm;
    int         m_lvl [8];
    int         m_nl  [8];
    logic [7:0] m_tgt;
    logic [7:0] m_led;
    logic [7:0] m_nled;
    bit         m_busy;
    bit         m_nbusy;
    bit         m_tick;
    bit         m_valid = 1'b0;

    function automatic bit model_on(int l, int p);
        if (l == 0)    return 1'b0;
        if (l == MAXL) return 1'b1;
        return l > p;
    endfunction

    function automatic int model_step(int l, bit up);
        if (up) return (l + STEPV > MAXL) ? MAXL : l + STEPV;
        return (l - STEPV < 0) ? 0 : l - STEPV;
    endfunction

    always @(posedge clk) begin
        if (HRESET) begin
            m_cnt = 0; m_pwm = 0; m_tgt = 8'h00; m_led = 8'h00; m_busy = 1'b0;
            m_tick = 1'b0; m_valid = 1'b1;
            for (int c = 0; c < 8; c++) m_lvl[c] = 0;
        end else begin
            m_tick  = enable && (m_cnt == TD - 1);
            m_nbusy = 1'b0;
            for (int c = 0; c < 8; c++) begin
                m_nled[c] = enable ? model_on(m_lvl[c], m_pwm) : 1'b0;
                if (enable && (m_lvl[c] != (m_tgt[c] ? MAXL : 0))) m_nbusy = 1'b1;
                if (!enable)     m_nl[c] = 0;
                else if (m_tick) m_nl[c] = model_step(m_lvl[c], m_tgt[c]);
                else             m_nl[c] = m_lvl[c];
            end
            for (int c = 0; c < 8; c++) begin
                m_lvl[c] = m_nl[c];
                if (m_lvl[c] < 0 || m_lvl[c] > MAXL) begin
                    errors++;
                    $display("FAIL lvl_range ch%0d: got %0d required 0..255", c, m_lvl[c]);
                end
            end
            m_led  = m_nled;
            m_busy = m_nbusy;
            m_tgt  = led_in;
            m_pwm  = (m_pwm + 1) % 256;
            m_cnt  = !enable ? 0 : ((m_cnt == TD - 1) ? 0 : m_cnt + 1);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            checks += 4;
            if (led_out !== m_led) begin
                errors++;
                $display("FAIL led_out @%0t: got %02h required %02h", $time, led_out, m_led);
            end
            if (led_out_al !== ~m_led) begin
                errors++;
                $display("FAIL led_out_al @%0t: got %02h required %02h", $time, led_out_al, ~m_led);
            end
            if (busy !== m_busy) begin
                errors++;
                $display("FAIL busy @%0t: got %0b required %0b", $time, busy, m_busy);
            end
            if (busy_al !== m_busy) begin
                errors++;
                $display("FAIL busy_al @%0t: got %0b required %0b", $time, busy_al, m_busy);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end else begin
            $display("check %s: %0d ok", name, act);
        end
    endtask

    task automatic wait_tick();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk); #1;
            if (m_tick) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL tick_timeout: got no tick required one within 64 cycles");
        end
    endtask

    task automatic reset_dut(input int n);
        @(posedge clk); #2;
        HRESET = 1'b1;
        repeat (n) @(posedge clk);
        #2;
        HRESET = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int c64, c128, cfull;
    int ramp_exp [4];

    initial begin
        ramp_exp = '{64, 128, 192, 255};

        // reset values
        repeat (3) @(posedge clk);
        #1;
        chk("reset_led_out", int'(led_out), 0);
        chk("reset_led_out_al", int'(led_out_al), 255);
        chk("reset_busy", int'(busy), 0);

        // duty measurements on the slow-tick instance, full-on on the fast one
        @(posedge clk); #2;
        HRESET = 1'b0; enable = 1'b1; led_in = 8'h01;
        c64 = 0; c128 = 0; cfull = 0;
        for (int n = 1; n <= 2256; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n >= 1001 && n <= 1256) c64   += int'(led_out_slow[0]);
            if (n >= 2001 && n <= 2256) c128  += int'(led_out_slow[0]);
            if (n >= 500  && n <= 755)  cfull += int'(led_out[0]);
            if (n == 500)  chk("settled_busy", int'(busy), 0);
            if (n == 2100) chk("slow_busy_mid", int'(busy_slow), 1);
        end
        chk("duty_lvl64", c64, 64);
        chk("duty_lvl128", c128, 128);
        chk("duty_full", cfull, 256);

        // ramp up on ch0
        reset_dut(3);
        enable = 1'b1; led_in = 8'h01;
        for (int i = 0; i < 4; i++) begin
            wait_tick();
            chk("ramp_lvl", m_lvl[0], ramp_exp[i]);
        end
        chk("ramp_busy_at_max", int'(busy), 1);
        @(posedge clk); #1;
        chk("ramp_busy_drop", int'(busy), 0);

        // mid-ramp reversal on ch3
        reset_dut(2);
        led_in = 8'h08;
        wait_tick();
        wait_tick();
        chk("rev_start", m_lvl[3], 128);
        led_in = 8'h00;
        wait_tick();
        chk("rev_step1", m_lvl[3], 64);
        wait_tick();
        chk("rev_step2", m_lvl[3], 0);

        // disable mid-ramp
        led_in = 8'hFF;
        wait_tick();
        wait_tick();
        enable = 1'b0;
        @(posedge clk); #1;
        chk("dis_led_out", int'(led_out), 0);
        chk("dis_led_out_al", int'(led_out_al), 255);
        chk("dis_busy", int'(busy), 0);
        chk("dis_lvl5", m_lvl[5], 0);

        // reset at lvl=192
        enable = 1'b1; led_in = 8'h01;
        wait_tick();
        wait_tick();
        wait_tick();
        chk("rst_mid_lvl", m_lvl[0], 192);
        HRESET = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_led_out", int'(led_out), 0);
        chk("rst_mid_led_out_al", int'(led_out_al), 255);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_lvl0", m_lvl[0], 0);
        HRESET = 1'b0;

        // one-hot pattern walk
        for (int ch = 0; ch < 8; ch++) begin
            led_in = 8'(1 << ch);
            repeat (8) wait_tick();
        end
        chk("walk_last_lvl7", m_lvl[7], 255);
        chk("walk_last_lvl6", m_lvl[6], 0);

        // random traffic
        for (int t = 0; t < 200; t++) begin
            led_in = 8'($urandom);
            enable = ($urandom_range(0, 9) != 0);
            HRESET = ($urandom_range(0, 49) == 0);
            repeat ($urandom_range(1, 24)) @(posedge clk);
            #1;
        end
        HRESET = 1'b0; enable = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_fade_driver.md
# led_fade_driver

Downstream output stage for the AHB-Lite LED slave: consumes its 8-bit LED pattern and drives the board pins with a soft fade in and out instead of hard on/off edges. Each channel's brightness level ramps toward full or zero at a programmable rate, and a per-cycle PWM compare renders that level. The block sits between the LED slave's `LED` output and the top-level pins, on the same HCLK domain.

## Interface
- `CH_NUM`, 8, number of LED channels
- `PWM_BITS`, 8, brightness and PWM counter width; MAX = 2^PWM_BITS-1
- `TICK_DIV`, 97656, HCLK cycles per brightness step (≥1)
- `STEP`, 8, level change per tick (1..MAX)
- `ACTIVE_LOW`, 0, 1 inverts `led_out` for sink-driven LEDs
- `HCLK` in 1: system clock, single clock domain
- `HRESET` in 1: synchronous, active-high reset
- `led_in` in CH_NUM: target pattern from the LED slave; bit=1 means ramp to full, bit=0 means ramp to off
- `enable` in 1: fade engine enable
- `led_out` out CH_NUM: registered PWM pin drive, polarity per `ACTIVE_LOW`
- `busy` out 1: registered; high while any channel's level ≠ its target endpoint

## Operation
- **Input register:** `led_in` is registered into `tgt` every cycle.
- **Tick counter:**
  - Counts 0..TICK_DIV-1, then wraps.
  - `tick` is high in the cycle where the count equals TICK_DIV-1.
- **PWM counter:** free-running, PWM_BITS wide, increments every cycle and wraps MAX→0.
- **Per-channel level update (`lvl`, PWM_BITS wide), on `tick` only:**
  - `tgt`=1: lvl ← min(lvl+STEP, MAX), with the sum computed at PWM_BITS+1 bits.
  - `tgt`=0: lvl ← max(lvl−STEP, 0), saturating with no underflow.
  - Otherwise lvl holds.
- **Compare (raw on):**
  - lvl==0 gives off.
  - lvl==MAX gives on (true 100% duty).
  - Any other level gives on when lvl > pwm_cnt.
- **Output:** `led_out` = raw_on XOR ACTIVE_LOW, registered.
- **busy:** busy ← OR over channels of (lvl ≠ (tgt ? MAX : 0)), registered.
- **enable=0:**
  - Tick counter held at 0.
  - All lvl forced to 0 on the next edge.
  - `led_out` driven to its off value.
  - `busy` driven to 0.
  - PWM counter keeps running.
- **Target change mid-ramp:** direction reverses at the next tick, starting from the current lvl. There is no restart from an endpoint.

## Timing
- **Reset:** while HRESET is high at an edge:
  - Tick counter, PWM counter, `tgt` and all `lvl` go to 0.
  - `led_out` = {CH_NUM{ACTIVE_LOW}}; `busy` = 0.
  - Reset asserted mid-ramp discards levels immediately; there is no residual fade.
- **Latency:**
  - `led_in` change to `tgt`: 1 cycle.
  - First lvl change: the first `tick` after `tgt` updates.
  - lvl change to `led_out`: 1 cycle.
  - `busy` reflects the new `tgt` 2 cycles after the `led_in` edge.
- **Full ramp length:** ceil(MAX/STEP) ticks.
- **Simultaneous events:**
  - `enable` falling on a tick cycle: the disable wins and lvl goes to 0.
  - `tgt` changing on a tick cycle: the step uses the old `tgt` (registered value).

## Structure
- Package `led_fade_pkg` holds:
  - Default parameter constants: TICK_DIV_DEFAULT, STEP_DEFAULT.
  - The `lvl_t` width.
  - The saturating add/sub function.
- Sub-module `led_fade_channel` contains one channel's lvl register, saturating step logic, compare and polarity flop. It is generate-instantiated CH_NUM times.
- The top level owns `tgt`, the tick counter, the PWM counter and the `busy` reduction.

## Test plan
Bench parameters: CH_NUM=8, PWM_BITS=8, TICK_DIV=4, STEP=64, ACTIVE_LOW=0, unless noted.
- **Reset:** hold HRESET high 3 cycles → `led_out`=0x00, `busy`=0. Repeat with ACTIVE_LOW=1 → `led_out`=0xFF.
- **Ramp up:** enable=1, `led_in`=0x01 → ch0 lvl steps 0→64→128→192→255 on successive ticks (4 ticks). `busy` is high and drops 1 cycle after lvl=255. ch0 `led_out` is then constant 1 over 256 cycles.
- **Duty check:** with lvl=128, count ch0 high cycles over 256 cycles → exactly 128. With lvl=64 → 64.
- **Mid-ramp reversal:** ramp ch3 to lvl=128, then set `led_in`=0x00 → lvl goes 128→64→0 on the next two ticks, with no 192 step.
- **Disable and reset mid-ramp:**
  - Drop enable during a ramp → all lvl=0 and `led_out`=0x00 next cycle.
  - Assert HRESET at lvl=192 → next cycle lvl=0 and `led_out`=0x00.
- **Pattern walk:** drive a one-hot pattern walking 0x01→0x02→… every 8 ticks → each channel rises to 255 then decays to 0. No channel's lvl exceeds 255 or wraps below 0.
